// File: rtl/inst_prefetch_queue_if.sv
`default_nettype none
// ============================================================================
//  Module      : inst_prefetch_queue_if
//  Description : Bundles the instruction-memory handshake, the redirect/stall
//                controls and the queue-head outputs of inst_prefetch_queue.
//                master = prefetch queue side, slave = memory/pipeline side.
//  Revision    : 1.0  initial release
// ============================================================================
interface inst_prefetch_queue_if #(
    parameter int DEPTH = 4
);
    localparam int c_CW = $clog2(DEPTH) + 1;

    // instruction memory handshake
    logic              mem_req;
    logic [31:0]       mem_addr;
    logic              mem_ack;
    logic [31:0]       mem_rdata;

    // pipeline control
    logic              redirect;
    logic [31:0]       redirect_pc;
    logic              stall;

    // queue head towards IF/ID
    logic              inst_valid;
    logic [31:0]       inst_out;
    logic [31:0]       inst_pc;
    logic [31:0]       inst_pc_plus_4;
    logic [c_CW-1:0]   count;

    modport master (
        output mem_req, mem_addr,
        input  mem_ack, mem_rdata,
        input  redirect, redirect_pc, stall,
        output inst_valid, inst_out, inst_pc, inst_pc_plus_4, count
    );

    modport slave (
        input  mem_req, mem_addr,
        output mem_ack, mem_rdata,
        output redirect, redirect_pc, stall,
        input  inst_valid, inst_out, inst_pc, inst_pc_plus_4, count
    );
endinterface
`default_nettype wire

// File: rtl/inst_prefetch_queue.sv
`default_nettype none
// ============================================================================
//  Module      : inst_prefetch_queue
//  Description : Instruction prefetch queue in front of the IF stage. Fetches
//                sequential words over a req/ack memory port (one request in
//                flight), buffers DEPTH {pc, inst} entries, presents the head
//                to IF/ID and flushes/refetches on redirect.
//                Optional macro PREFETCH_BYPASS_EN: forward an ack straight to
//                the head outputs when the queue is empty.
//  Revision    : 1.0  initial release
// ============================================================================
module inst_prefetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  wire logic              clk,
    input  wire logic              rst,   // asynchronous, active-low
    inst_prefetch_queue_if.master  bus
);
    localparam int              c_PW   = $clog2(DEPTH);
    localparam int              c_CW   = c_PW + 1;
    localparam logic [c_CW-1:0] c_FULL = c_CW'(DEPTH);

    localparam logic [1:0] c_ST_IDLE    = 2'd0;
    localparam logic [1:0] c_ST_WAIT    = 2'd1;
    localparam logic [1:0] c_ST_DISCARD = 2'd2;

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [31:0]      r_fetch_pc;
    logic [31:0]      r_stale_addr;     // address of the request being thrown away
    logic [c_PW-1:0]  r_head;
    logic [c_PW-1:0]  r_tail;
    logic [c_CW-1:0]  r_count;
    logic [c_CW-1:0]  w_count_nxt;
    logic [31:0]      r_pc_mem   [DEPTH];
    logic [31:0]      r_inst_mem [DEPTH];

    logic             w_ack_wait;
    logic             w_q_valid;
    logic             w_pop_q;
    logic             w_push;
    logic             w_bypass;
    logic             w_head_valid;
    logic [31:0]      w_head_inst;
    logic [31:0]      w_head_pc;

    // An ack only carries usable data while a live (non-discarded) request is out
    assign w_ack_wait = (r_state == c_ST_WAIT) && bus.mem_ack;
    assign w_q_valid  = (r_count != '0);
    // Redirect kills any pop from the queue this cycle
    assign w_pop_q    = w_q_valid && !bus.stall && !bus.redirect;

`ifdef PREFETCH_BYPASS_EN
    // Empty queue: the returning word goes straight to the head outputs and is
    // only written into storage when IF/ID cannot take it this cycle
    assign w_bypass = !w_q_valid && w_ack_wait && !bus.redirect;
    assign w_push   = w_ack_wait && !bus.redirect && !(w_bypass && !bus.stall);
`else
    assign w_bypass = 1'b0;
    assign w_push   = w_ack_wait && !bus.redirect;
`endif

    // A push is never issued against a full queue: a request only exists with a
    // slot reserved, so this sum stays within 0..DEPTH
    assign w_count_nxt = r_count + c_CW'(w_push) - c_CW'(w_pop_q);

    // Next-state logic: one outstanding request, redirect has priority
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (bus.redirect || (w_count_nxt < c_FULL)) begin
                    w_state_nxt = c_ST_WAIT;
                end
            end
            c_ST_WAIT: begin
                if (bus.redirect) begin
                    // an unanswered request must still be drained
                    w_state_nxt = bus.mem_ack ? c_ST_WAIT : c_ST_DISCARD;
                end else if (bus.mem_ack && (w_count_nxt >= c_FULL)) begin
                    w_state_nxt = c_ST_IDLE;
                end
            end
            c_ST_DISCARD: begin
                if (bus.mem_ack) begin
                    w_state_nxt = c_ST_WAIT;
                end
            end
            default: w_state_nxt = c_ST_IDLE;
        endcase
    end

    // Control state, fetch address and queue pointers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= c_ST_IDLE;
            r_fetch_pc   <= RESET_PC;
            r_stale_addr <= RESET_PC;
            r_head       <= '0;
            r_tail       <= '0;
            r_count      <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (bus.redirect) begin
                r_fetch_pc <= {bus.redirect_pc[31:2], 2'b00};
                r_head     <= r_tail;
                r_count    <= '0;
                // keep presenting the old address until its ack comes back
                if ((r_state == c_ST_WAIT) && !bus.mem_ack) begin
                    r_stale_addr <= r_fetch_pc;
                end
            end else begin
                if (w_ack_wait) begin
                    r_fetch_pc <= r_fetch_pc + 32'd4;
                end
                if (w_push) begin
                    r_tail <= r_tail + 1'b1;
                end
                if (w_pop_q) begin
                    r_head <= r_head + 1'b1;
                end
                r_count <= w_count_nxt;
            end
        end
    end

    // Entry storage; contents are only observed behind a valid count
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_pc_mem[r_tail]   <= r_fetch_pc;
            r_inst_mem[r_tail] <= bus.mem_rdata;
        end
    end

    // Head selection: queue entry, or the in-flight word when bypassing
    always_comb begin
        w_head_valid = w_q_valid;
        w_head_inst  = r_inst_mem[r_head];
        w_head_pc    = r_pc_mem[r_head];
        if (w_bypass) begin
            w_head_valid = 1'b1;
            w_head_inst  = bus.mem_rdata;
            w_head_pc    = r_fetch_pc;
        end
    end

    assign bus.mem_req        = (r_state != c_ST_IDLE);
    assign bus.mem_addr       = (r_state == c_ST_DISCARD) ? r_stale_addr : r_fetch_pc;
    assign bus.inst_valid     = w_head_valid;
    assign bus.inst_out       = w_head_valid ? w_head_inst : 32'h0;
    assign bus.inst_pc        = w_head_valid ? w_head_pc : 32'h0;
    assign bus.inst_pc_plus_4 = w_head_valid ? (w_head_pc + 32'd4) : 32'h0;
    assign bus.count          = r_count;

endmodule
`default_nettype wire
